lcd_hd44780_ctrl: RTL

- Downstream consumer of the BER display stage: receives its character-write stream (lcd_row/lcd_col/lcd_char/lcd_we), stores it in a 2x16 shadow buffer, and drives an HD44780-compatible panel in 4-bit mode.
- Reports lcd_busy back to the writer.
- Starts a full-panel refresh on each update pulse.

---
 rtl/lcd_pkg.sv | 47 ++++
 rtl/lcd_byte_tx.sv | 123 ++++++++++++
 rtl/lcd_hd44780_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and command bytes for the HD44780 4-bit panel driver.
// Imported by the byte transmitter and the top-level sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    INIT_WAIT,
    INIT_NIB,
    INIT_CMD,
    IDLE,
    REF
  } state_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_EH,
    T_EL,
    T_WAIT
  } tx_state_e;

  localparam logic [7:0] FUNC_SET = 8'h28;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] DDRAM_R0 = 8'h80;
  localparam logic [7:0] DDRAM_R1 = 8'hC0;
  localparam logic [7:0] SPACE    = 8'h20;

  // Init nibbles travel in the upper half of the byte.
  localparam logic [7:0] WAKE  = 8'h30;
  localparam logic [7:0] MODE4 = 8'h20;

  localparam logic [5:0] INIT_NIBS = 6'd4;
  localparam logic [5:0] INIT_CMDS = 6'd4;
  localparam logic [5:0] ROW1_IDX  = 6'd17;
  localparam logic [5:0] REF_LEN   = 6'd34;

  // Refresh byte index (1..16, 18..33) to {row, col}.
  function automatic logic [4:0] ref_addr(
    input logic [5:0] idx
  );
    if (idx <= 6'd16)
      return {1'b0, 4'(idx - 6'd1)};
    else
      return {1'b1, 4'(idx - 6'd18)};
  endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// Sends one byte (or one nibble) to the panel in 4-bit mode,
// then holds off for the command execution time.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int CYC_EN  = 12,
  parameter int CYC_CMD = 2500,
  parameter int CYC_CLR = 100000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       rs,
  input  logic       nibble_only,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [3:0] lcd_db
);

  localparam int CW = $clog2(CYC_CLR + 1);
  localparam logic [CW-1:0] EN_LD  = CW'(CYC_EN - 1);
  localparam logic [CW-1:0] CMD_LD = CW'(CYC_CMD - 1);
  localparam logic [CW-1:0] CLR_LD = CW'(CYC_CLR - 1);

  tx_state_e     st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          hi, hi_n;
  logic [3:0]    lo, lo_n;
  logic          nib, nib_n;
  logic          lng, lng_n;
  logic          e_n, rs_n;
  logic [3:0]    db_n;
  logic          ready;

  // Phase register and registered panel pins; E drops on reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st     <= T_IDLE;
      cnt    <= '0;
      hi     <= 1'b0;
      lo     <= 4'h0;
      nib    <= 1'b0;
      lng    <= 1'b0;
      lcd_e  <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_db <= 4'h0;
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      hi     <= hi_n;
      lo     <= lo_n;
      nib    <= nib_n;
      lng    <= lng_n;
      lcd_e  <= e_n;
      lcd_rs <= rs_n;
      lcd_db <= db_n;
    end
  end

  // Phase sequencing; a new start is taken on the done cycle
  // so back-to-back bytes have no gap.
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    hi_n  = hi;
    lo_n  = lo;
    nib_n = nib;
    lng_n = lng;
    e_n   = lcd_e;
    rs_n  = lcd_rs;
    db_n  = lcd_db;
    done  = (st == T_WAIT) && (cnt == '0);
    ready = (st == T_IDLE) || done;
    unique case (st)
      T_IDLE: ;
      T_EH: begin
        if (cnt == '0) begin
          st_n  = T_EL;
          cnt_n = EN_LD;
          e_n   = 1'b0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      T_EL: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (hi && !nib) begin
          st_n  = T_EH;
          cnt_n = EN_LD;
          e_n   = 1'b1;
          db_n  = lo;
          hi_n  = 1'b0;
        end else begin
          st_n  = T_WAIT;
          cnt_n = lng ? CLR_LD : CMD_LD;
        end
      end
      T_WAIT: begin
        if (cnt == '0)
          st_n = T_IDLE;
        else
          cnt_n = cnt - 1'b1;
      end
      default: st_n = T_IDLE;
    endcase
    if (start && ready) begin
      st_n  = T_EH;
      cnt_n = EN_LD;
      e_n   = 1'b1;
      db_n  = data[7:4];
      lo_n  = data[3:0];
      rs_n  = rs;
      hi_n  = 1'b1;
      nib_n = nibble_only;
      lng_n = long_wait;
    end
  end

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// 2x16 shadow buffer plus init/refresh sequencer for an
// HD44780 panel in 4-bit mode.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int CYC_EN   = 12,
  parameter int CYC_CMD  = 2500,
  parameter int CYC_CLR  = 100000,
  parameter int CYC_INIT = 750000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       lcd_we,
  input  logic       lcd_row,
  input  logic [3:0] lcd_col,
  input  logic [7:0] lcd_char,
  input  logic       update,
  output logic       lcd_busy,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [3:0] LCD_DB
);

  localparam int DW = $clog2(CYC_INIT + 1);
  localparam logic [DW-1:0] INIT_LD = DW'(CYC_INIT - 1);

  state_e        state, state_n;
  logic [5:0]    idx, idx_n;
  logic [DW-1:0] dly, dly_n;
  logic          pending, pend_n;
  logic [7:0]    mem [32];

  logic       start, tx_done, go_ref;
  logic [7:0] tx_data;
  logic       tx_rs, tx_nib, tx_long;
  logic [7:0] rd_data;

  assign LCD_RW  = 1'b0;
  assign rd_data = mem[ref_addr(idx)];

  // Shadow buffer; writes are accepted in every state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 32; i++)
        mem[i] <= SPACE;
    end else if (lcd_we) begin
      mem[{lcd_row, lcd_col}] <= lcd_char;
    end
  end

  // Sequencer state, counters, pending request and busy.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= INIT_WAIT;
      idx      <= 6'd0;
      dly      <= INIT_LD;
      pending  <= 1'b0;
      lcd_busy <= 1'b1;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      dly      <= dly_n;
      pending  <= pend_n;
      lcd_busy <= (state_n != IDLE);
    end
  end

  // Next state and the byte to hand to the transmitter.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    dly_n   = dly;
    pend_n  = pending | (update & (state != IDLE));
    start   = 1'b0;
    tx_data = 8'h00;
    tx_rs   = 1'b0;
    tx_nib  = 1'b0;
    tx_long = 1'b0;
    go_ref  = 1'b0;
    unique case (state)
      INIT_WAIT: begin
        if (dly == '0) begin
          start   = 1'b1;
          tx_data = WAKE;
          tx_nib  = 1'b1;
          tx_long = 1'b1;
          idx_n   = 6'd1;
          state_n = INIT_NIB;
        end else begin
          dly_n = dly - 1'b1;
        end
      end
      INIT_NIB: begin
        if (tx_done) begin
          start = 1'b1;
          if (idx == INIT_NIBS) begin
            tx_data = FUNC_SET;
            idx_n   = 6'd1;
            state_n = INIT_CMD;
          end else begin
            tx_data = (idx == 6'd3) ? MODE4 : WAKE;
            tx_nib  = 1'b1;
            tx_long = 1'b1;
            idx_n   = idx + 6'd1;
          end
        end
      end
      INIT_CMD: begin
        if (tx_done) begin
          if (idx == INIT_CMDS) begin
            go_ref  = pending | update;
            state_n = IDLE;
          end else begin
            start = 1'b1;
            idx_n = idx + 6'd1;
            unique case (1'b1)
              idx == 6'd1: tx_data = DISP_ON;
              idx == 6'd2: tx_data = ENTRY;
              default: begin
                tx_data = CLEAR;
                tx_long = 1'b1;
              end
            endcase
          end
        end
      end
      IDLE: go_ref = update;
      REF: begin
        if (tx_done) begin
          if (idx == REF_LEN) begin
            go_ref  = pending | update;
            state_n = IDLE;
          end else begin
            start = 1'b1;
            idx_n = idx + 6'd1;
            if (idx == ROW1_IDX) begin
              tx_data = DDRAM_R1;
            end else begin
              tx_data = rd_data;
              tx_rs   = 1'b1;
            end
          end
        end
      end
      default: state_n = INIT_WAIT;
    endcase
    if (go_ref) begin
      start   = 1'b1;
      tx_data = DDRAM_R0;
      tx_rs   = 1'b0;
      tx_nib  = 1'b0;
      tx_long = 1'b0;
      idx_n   = 6'd1;
      state_n = REF;
      pend_n  = 1'b0;
    end
  end

  lcd_byte_tx #(
    .CYC_EN  (CYC_EN),
    .CYC_CMD (CYC_CMD),
    .CYC_CLR (CYC_CLR)
  ) u_tx (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .data        (tx_data),
    .rs          (tx_rs),
    .nibble_only (tx_nib),
    .long_wait   (tx_long),
    .done        (tx_done),
    .lcd_e       (LCD_E),
    .lcd_rs      (LCD_RS),
    .lcd_db      (LCD_DB)
  );

endmodule
